// File: rtl/digit_step_counter.sv
// Button-driven 3-bit up/down counter feeding the 7-segment decoder inputs B,C,D.
// Debounces step and run/stop buttons; run mode steps the count at a fixed tick rate.
module digit_step_counter #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TICK_DIV        = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_step,
    input  logic btn_run,
    input  logic dir,
    output logic B,
    output logic C,
    output logic D,
    output logic running,
    output logic wrap
);

    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned PsW = $clog2(TICK_DIV);
    localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PsW-1:0] PsMax = PsW'(TICK_DIV - 1);

    typedef enum logic {StIdle, StRun} state_e;

    // Bit 0: step button, bit 1: run button, bit 2: direction switch.
    logic [2:0] meta_q, sync_q;

    logic [1:0]     deb_q, deb_d, deb_dly_q;
    logic [DbW-1:0] db_cnt_q [2];
    logic [DbW-1:0] db_cnt_d [2];

    state_e         state_q, state_d;
    logic [PsW-1:0] presc_q, presc_d;
    logic [2:0]     count_q, count_d;
    logic           wrap_q, wrap_d;

    logic [1:0] press;
    logic       step_press, run_press, tick, step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= {dir, btn_run, btn_step};
            sync_q <= meta_q;
        end
    end

    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = '0;
            if (sync_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DbMax) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q     <= '0;
            deb_dly_q <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign press      = deb_q & ~deb_dly_q;
    assign step_press = press[0];
    assign run_press  = press[1];

    // Run FSM: state register, next state, outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (run_press) begin
            state_d = (state_q == StIdle) ? StRun : StIdle;
        end
    end

    always_comb begin
        running = (state_q == StRun);
    end

    // A stop press in the tick cycle wins, so no step slips out while leaving RUN.
    assign tick = running && !run_press && (presc_q == PsMax);

    always_comb begin
        presc_d = '0;
        if (running && !run_press && !tick) begin
            presc_d = presc_q + 1'b1;
        end
    end

    assign step = step_press | tick;

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (step) begin
            if (sync_q[2]) begin
                count_d = count_q + 3'd1;
                wrap_d  = (count_q == 3'd7);
            end else begin
                count_d = count_q - 3'd1;
                wrap_d  = (count_q == 3'd0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign B    = count_q[2];
    assign C    = count_q[1];
    assign D    = count_q[0];
    assign wrap = wrap_q;

endmodule

// File: tb/tb_digit_step_counter.sv
// Bench for digit_step_counter: directed button/dir vectors, a cycle-level behavioural
// model checked every cycle, plus hand-computed expectations at key points.
module tb_digit_step_counter;

    localparam int DB = 4;
    localparam int TD = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_step = 1'b0;
    logic btn_run = 1'b0;
    logic dir = 1'b1;
    logic B, C, D, running, wrap;

    int checks = 0;
    int errors = 0;

    digit_step_counter #(
        .DEBOUNCE_CYCLES(DB),
        .TICK_DIV       (TD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_step(btn_step),
        .btn_run (btn_run),
        .dir     (dir),
        .B       (B),
        .C       (C),
        .D       (D),
        .running (running),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic press_step();
        btn_step = 1'b1;
        cyc(10);
        btn_step = 1'b0;
        cyc(10);
    endtask

    // Model: raw -> 2-sample delay, streak-based debounce, rising-edge events,
    // ticks every TD edges counted from the edge that entered RUN, count mod 8.
    int   n;
    bit   [2:0] m_meta, m_sync;
    bit   [1:0] m_deb, m_deb_prev;
    int   m_streak [2];
    bit   m_run;
    int   m_run_start;
    int   m_count;
    bit   m_wrap;
    bit   sp, rp, tk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0; m_meta = '0; m_sync = '0; m_deb = '0; m_deb_prev = '0;
            m_streak[0] = 0; m_streak[1] = 0;
            m_run = 0; m_run_start = 0; m_count = 0; m_wrap = 0;
        end else begin
            n = n + 1;
            sp = m_deb[0] && !m_deb_prev[0];
            rp = m_deb[1] && !m_deb_prev[1];
            tk = m_run && !rp && ((n - m_run_start) % TD == 0);
            m_wrap = 0;
            if (sp || tk) begin
                if (m_sync[2]) begin
                    m_wrap  = (m_count == 7);
                    m_count = (m_count + 1) % 8;
                end else begin
                    m_wrap  = (m_count == 0);
                    m_count = (m_count + 7) % 8;
                end
            end
            if (rp) begin
                m_run = !m_run;
                m_run_start = n;
            end
            m_deb_prev = m_deb;
            for (int b = 0; b < 2; b++) begin
                if (m_sync[b] != m_deb[b]) begin
                    m_streak[b]++;
                    if (m_streak[b] == DB) begin
                        m_deb[b] = !m_deb[b];
                        m_streak[b] = 0;
                    end
                end else begin
                    m_streak[b] = 0;
                end
            end
            m_sync = m_meta;
            m_meta = {dir, btn_run, btn_step};
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_count", int'({B, C, D}), m_count);
            chk("model_running", int'(running), int'(m_run));
            chk("model_wrap", int'(wrap), int'(m_wrap));
        end
    end

    initial begin
        #1;
        chk("reset_bcd", int'({B, C, D}), 0);
        chk("reset_running", int'(running), 0);
        chk("reset_wrap", int'(wrap), 0);
        cyc(3);
        rst_n = 1'b1;
        cyc(3);

        // Clean press, dir up: count changes exactly at edge 7.
        btn_step = 1'b1;
        cyc(6);
        chk("press_edge6", int'({B, C, D}), 0);
        cyc(1);
        chk("press_edge7", int'({B, C, D}), 1);
        cyc(13);
        btn_step = 1'b0;
        cyc(10);
        chk("press_hold_release", int'({B, C, D}), 1);

        // Bounce then settle high: one event; short glitch: none.
        for (int k = 0; k < 6; k++) begin
            btn_step = (k % 2 == 0);
            cyc(2);
        end
        btn_step = 1'b1;
        cyc(15);
        chk("bounce_one_step", int'({B, C, D}), 2);
        btn_step = 1'b0;
        cyc(10);
        btn_step = 1'b1;
        cyc(3);
        btn_step = 1'b0;
        cyc(10);
        chk("glitch_rejected", int'({B, C, D}), 2);

        // Down wrap 0 -> 7, then up wrap 7 -> 0.
        dir = 1'b0;
        cyc(3);
        press_step();
        press_step();
        chk("down_to_zero", int'({B, C, D}), 0);
        btn_step = 1'b1;
        cyc(7);
        chk("down_wrap_count", int'({B, C, D}), 7);
        chk("down_wrap_pulse", int'(wrap), 1);
        cyc(1);
        chk("down_wrap_one_cycle", int'(wrap), 0);
        cyc(3);
        btn_step = 1'b0;
        cyc(10);
        dir = 1'b1;
        cyc(3);
        btn_step = 1'b1;
        cyc(7);
        chk("up_wrap_count", int'({B, C, D}), 0);
        chk("up_wrap_pulse", int'(wrap), 1);
        cyc(3);
        btn_step = 1'b0;
        cyc(10);

        // Auto-run: RUN set at edge E, ticks at E+10, E+20, ...
        btn_run = 1'b1;
        cyc(7);
        chk("run_on", int'(running), 1);
        chk("run_start_count", int'({B, C, D}), 0);
        btn_run = 1'b0;
        cyc(10);
        chk("first_tick", int'({B, C, D}), 1);
        cyc(60);
        chk("tick_seven", int'({B, C, D}), 7);
        cyc(10);
        chk("run_wrap_count", int'({B, C, D}), 0);
        chk("run_wrap_pulse", int'(wrap), 1);

        // Step press coincident with the tick at E+90: single advance.
        cyc(3);
        btn_step = 1'b1;
        cyc(7);
        chk("coincident_single_step", int'({B, C, D}), 1);
        cyc(3);
        btn_step = 1'b0;
        dir = 1'b0;
        cyc(7);
        chk("dir_reversed_tick", int'({B, C, D}), 0);
        cyc(10);
        chk("dir_reversed_wrap_count", int'({B, C, D}), 7);
        chk("dir_reversed_wrap_pulse", int'(wrap), 1);

        // Stop press landing on the E+120 tick edge: tick suppressed.
        cyc(3);
        btn_run = 1'b1;
        cyc(7);
        chk("run_off", int'(running), 0);
        chk("stop_suppresses_tick", int'({B, C, D}), 7);
        cyc(3);
        btn_run = 1'b0;
        cyc(30);
        chk("frozen_after_stop", int'({B, C, D}), 7);

        // Mid-cycle reset at count 5 with step button held through release.
        press_step();
        press_step();
        chk("count_five", int'({B, C, D}), 5);
        btn_step = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_bcd", int'({B, C, D}), 0);
        chk("async_reset_running", int'(running), 0);
        chk("async_reset_wrap", int'(wrap), 0);
        @(negedge clk);
        cyc(2);
        rst_n = 1'b1;
        cyc(6);
        chk("held_through_reset_edge6", int'({B, C, D}), 0);
        cyc(1);
        chk("held_through_reset_edge7", int'({B, C, D}), 7);
        chk("held_through_reset_wrap", int'(wrap), 1);
        btn_step = 1'b0;
        cyc(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
